data_mem_if: RTL and testbench
==============================

# data_mem_if

Multicycle data-memory interface between the processor datapath and a single-port synchronous word-wide data RAM. The datapath starts a load or store when the controller's main FSM reaches a memory state, and stalls until `ready`. The block converts byte/halfword/word accesses selected by `funct3` into word address, byte enables and lane-replicated write data. Load data is returned sign- or zero-extended and right-aligned, so the writeback mux needs no further processing.

## Interface
Parameters:
- `READ_LAT`, default 1: RAM read latency in cycles from `mem_en` to valid `mem_rdata`. Legal range is 1..8.

Ports:
- `clk` in 1: clock. One clock domain; everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: access request. Sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: access size and signedness. Encodings follow RISC-V load/store.
- `addr` in 32: byte address.
- `wdata` in 32: store data, taken from the low bits.
- `rdata` out 32: extended load result. Held until the next load completes.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: misalignment flag, valid with `ready`. Present only with `MISALIGN_TRAP_EN`.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 30: word address, equal to `addr[31:2]`.
- `mem_be` out 4: byte write enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: RAM read data.

## Operation
- In IDLE with `req`=1, capture `we`, `funct3`, `addr` and `wdata` into internal registers. Inputs are don't-care after capture.
- State machine:
  - IDLE → ACCESS.
  - ACCESS → DONE for a store, or ACCESS → WAIT for a load.
  - WAIT → DONE after READ_LAT cycles.
  - DONE → IDLE.
- ACCESS drives `mem_en`=1 for exactly one cycle, with `mem_we`=`we`. `mem_en` is 0 in every other state.
- Store lane mapping by `funct3`:
  - sb (000): `mem_be` = 1<<`addr[1:0]`; `mem_wdata` = `wdata[7:0]` replicated ×4.
  - sh (001): `mem_be` = 0011 if `addr[1]`=0, else 1100; `mem_wdata` = `wdata[15:0]` replicated ×2.
  - sw (010) and all other codes: `mem_be` = 1111; `mem_wdata` = `wdata`.
- `mem_be` = 0000 whenever `mem_we`=0.
- Load extraction: WAIT captures `mem_rdata` on its last cycle. The byte is selected by `addr[1:0]` and the halfword by `addr[1]`.
  - lb (000) and lh (001) sign-extend.
  - lbu (100) and lhu (101) zero-extend.
  - lw (010) and the unused codes 011, 110, 111 pass the full word.
- Extraction result is written to `rdata` when leaving WAIT.
- A store never modifies `rdata`.
- WAIT uses a 3-bit down-counter loaded with READ_LAT−1 on entry. WAIT exits when the counter is 0.
- Misalignment without the macro: unused low address bits are ignored.
  - Halfword accesses use only `addr[1]`.
  - Word accesses use neither `addr[1]` nor `addr[0]`.

## Timing
- Reset: state = IDLE, counter = 0, `rdata` = 0. All outputs are 0: `ready`, `busy`, `err`, `mem_en`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`.
- Reset during any state returns to IDLE on the next edge. No further `mem_en` is issued after that edge. A store already issued in ACCESS is not undone.
- Store: `req` sampled at edge 0. ACCESS runs in cycle 1. `ready`=1 in cycle 2. Total 2 cycles.
- Load: `req` sampled at edge 0. ACCESS in cycle 1. WAIT in cycles 2..1+READ_LAT. `ready` and valid `rdata` in cycle 2+READ_LAT.
- `req` is ignored while `busy`=1, including in DONE. The earliest next acceptance is the cycle after DONE.
- `ready` is never high for more than one consecutive cycle.
- All outputs are registered or decoded only from state and captured registers. No combinational path exists from `req`, `addr` or `mem_rdata` to any output.

## Configuration
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned request goes IDLE → DONE directly, with no `mem_en`.
  - Misaligned means lh, lhu or sh with `addr[0]`=1; or lw/sw (and the unused codes) with `addr[1:0]`≠00.
  - `ready`=1 and `err`=1 in cycle 1; `rdata` is unchanged.
  - `err`=0 on every aligned completion.
- Undefined: `err` port and trap logic are absent. Misaligned addresses are truncated as described under Operation.

## Test plan
- Store sb, `addr`=0x1003, `wdata`=0x000000A5 → cycle 1: `mem_en`=1, `mem_we`=1, `mem_addr`=0x400, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5. `ready` in cycle 2.
- RAM word 0x80F0_1234, READ_LAT=1: lb at `addr` offset 3 → `rdata`=0xFFFFFF80 in cycle 3. lhu at offset 2 → `rdata`=0x000080F0. lw → `rdata`=0x80F01234.
- READ_LAT=4, lh at `addr` offset 0 on word 0x0000_F00D → `ready` in cycle 6 with `rdata`=0xFFFFF00D. `mem_en` is high in exactly one cycle.
- `req` held high continuously across two stores → second ACCESS occurs exactly 3 cycles after the first. No request is captured during ACCESS or DONE.
- Reset asserted in the WAIT cycle of a load → next cycle: IDLE, `busy`=0, `rdata`=0, and no `ready` pulse.
- With `MISALIGN_TRAP_EN`, sw at `addr`=0x2002 → `ready`=1 and `err`=1 in cycle 1, `mem_en` never asserted. Without the macro, the same request writes `mem_addr`=0x800 with `mem_be`=1111.

Source files
------------

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - multicycle load/store interface to a single-port word RAM
// Optional MISALIGN_TRAP_EN: misaligned requests complete immediately with err and no RAM access.
module data_mem_if #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
`ifdef MISALIGN_TRAP_EN
    output logic        err,
`endif
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       we_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic       trap;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return off[0];
            default:        return off != 2'b00;
        endcase
    endfunction

    assign trap = misaligned(funct3, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            off_q     <= 2'd0;
            rdata     <= 32'd0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            err       <= 1'b0;
`endif
        end else begin
            // Pulsed outputs default low; only the transitions below raise them.
            ready  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'd0;
`ifdef MISALIGN_TRAP_EN
            err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q      <= we;
                        funct3_q  <= funct3;
                        off_q     <= addr[1:0];
                        mem_addr  <= addr[31:2];
                        mem_wdata <= store_data(funct3, wdata);
                        busy      <= 1'b1;
                        if (trap) begin
                            state <= DONE;
                            ready <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                            err   <= 1'b1;
`endif
                        end else begin
                            state  <= ACCESS;
                            mem_en <= 1'b1;
                            mem_we <= we;
                            mem_be <= we ? store_be(funct3, addr[1:0]) : 4'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        rdata <= load_extract(funct3_q, off_q, mem_rdata);
                        state <= DONE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_if.sv
// tb/tb_data_mem_if.sv - directed bench for data_mem_if with READ_LAT=1 and READ_LAT=4 instances
module tb_data_mem_if;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic [31:0] rdata1, rdata4, mem_wdata1, mem_wdata4, mem_rdata1, mem_rdata4;
    logic        ready1, ready4, busy1, busy4, mem_en1, mem_en4, mem_we1, mem_we4;
    logic [29:0] mem_addr1, mem_addr4;
    logic [3:0]  mem_be1, mem_be4;
`ifdef MISALIGN_TRAP_EN
    logic        err1, err4;
`endif

    int vec = 0;
    int miss = 0;

    always #5 clk = ~clk;

    data_mem_if #(.READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .busy(busy1),
`ifdef MISALIGN_TRAP_EN
        .err(err1),
`endif
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_be(mem_be1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    data_mem_if #(.READ_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .ready(ready4), .busy(busy4),
`ifdef MISALIGN_TRAP_EN
        .err(err4),
`endif
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_be(mem_be4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
    );

    // RAM models: read data is only valid exactly READ_LAT cycles after mem_en.
    logic [31:0] ram1 [16];
    logic [31:0] ram4 [16];
    logic        pv1;
    logic [31:0] pd1;
    logic [3:0]  pv4;
    logic [31:0] pd4 [4];

    assign mem_rdata1 = pv1 ? pd1 : 32'hDEADBEEF;
    assign mem_rdata4 = pv4[3] ? pd4[3] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                ram1[i] <= 32'd0;
                ram4[i] <= 32'd0;
            end
            ram1[1] <= 32'h80F01234;
            ram4[1] <= 32'h80F01234;
            ram1[2] <= 32'h0000F00D;
            ram4[2] <= 32'h0000F00D;
            pv1 <= 1'b0;
            pv4 <= 4'd0;
        end else begin
            if (mem_en1 && mem_we1)
                for (int b = 0; b < 4; b++)
                    if (mem_be1[b]) ram1[mem_addr1[3:0]][8*b +: 8] <= mem_wdata1[8*b +: 8];
            if (mem_en4 && mem_we4)
                for (int b = 0; b < 4; b++)
                    if (mem_be4[b]) ram4[mem_addr4[3:0]][8*b +: 8] <= mem_wdata4[8*b +: 8];
            pv1 <= mem_en1 && !mem_we1;
            pd1 <= ram1[mem_addr1[3:0]];
            pv4 <= {pv4[2:0], mem_en4 && !mem_we4};
            pd4[0] <= ram4[mem_addr4[3:0]];
            for (int s = 1; s < 4; s++) pd4[s] <= pd4[s-1];
        end
    end

    int          en_cnt1, en_cnt4, en_cyc1, rdy_cnt1, rdy_cnt4, rdy_cyc1, rdy_cyc4;
    logic [31:0] rd_at1, rd_at4, wd_s1;
    logic [29:0] ad_s1, ad_s4;
    logic [3:0]  be_s1;
    logic        we_s1, err_at1;

    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input int ncyc);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        en_cnt1 = 0; en_cnt4 = 0; en_cyc1 = 0; rdy_cnt1 = 0; rdy_cnt4 = 0;
        rdy_cyc1 = 0; rdy_cyc4 = 0; rd_at1 = 32'hX; rd_at4 = 32'hX; err_at1 = 1'bX;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
        for (int c = 1; c <= ncyc; c++) begin
            if (mem_en1) begin
                en_cnt1++; en_cyc1 = c; be_s1 = mem_be1; ad_s1 = mem_addr1;
                wd_s1 = mem_wdata1; we_s1 = mem_we1;
            end
            if (mem_en4) begin en_cnt4++; ad_s4 = mem_addr4; end
            if (ready1) begin
                rdy_cnt1++; rdy_cyc1 = c; rd_at1 = rdata1;
`ifdef MISALIGN_TRAP_EN
                err_at1 = err1;
`endif
            end
            if (ready4) begin rdy_cnt4++; rdy_cyc4 = c; rd_at4 = rdata4; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++; if (rdata1 !== 32'd0) begin miss++; $display("FAIL reset_rdata got %h want 0", rdata1); end
        vec++; if ({ready1, busy1, mem_en1, mem_we1} !== 4'd0) begin miss++; $display("FAIL reset_ctrl got %b want 0000", {ready1, busy1, mem_en1, mem_we1}); end
        vec++; if ({mem_be1, mem_addr1, mem_wdata1} !== 66'd0) begin miss++; $display("FAIL reset_mem_bus got %h want 0", {mem_be1, mem_addr1, mem_wdata1}); end
        vec++; if ({rdata4, busy4, ready4, mem_en4} !== 35'd0) begin miss++; $display("FAIL reset_dut4 got %h want 0", {rdata4, busy4, ready4, mem_en4}); end
`ifdef MISALIGN_TRAP_EN
        vec++; if ({err1, err4} !== 2'b00) begin miss++; $display("FAIL reset_err got %b want 00", {err1, err4}); end
`endif
        reset = 1'b0; preload = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] e;
    } ld_t;

    task automatic test_loads;
        ld_t lt[6];
        lt[0] = '{3'b000, 32'h0000_0007, 32'hFFFFFF80};
        lt[1] = '{3'b101, 32'h0000_0006, 32'h000080F0};
        lt[2] = '{3'b010, 32'h0000_0004, 32'h80F01234};
        lt[3] = '{3'b100, 32'h0000_0007, 32'h00000080};
        lt[4] = '{3'b001, 32'h0000_0006, 32'hFFFF80F0};
        lt[5] = '{3'b001, 32'h0000_0008, 32'hFFFFF00D};
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, lt[i].f, lt[i].a, 32'd0, 9);
            vec++; if (rd_at1 !== lt[i].e) begin miss++; $display("FAIL load%0d_rl1_rdata got %h want %h", i, rd_at1, lt[i].e); end
            vec++; if (rd_at4 !== lt[i].e) begin miss++; $display("FAIL load%0d_rl4_rdata got %h want %h", i, rd_at4, lt[i].e); end
            vec++; if (rdy_cyc1 !== 3 || rdy_cnt1 !== 1) begin miss++; $display("FAIL load%0d_rl1_ready got cyc %0d cnt %0d want cyc 3 cnt 1", i, rdy_cyc1, rdy_cnt1); end
            vec++; if (rdy_cyc4 !== 6 || rdy_cnt4 !== 1) begin miss++; $display("FAIL load%0d_rl4_ready got cyc %0d cnt %0d want cyc 6 cnt 1", i, rdy_cyc4, rdy_cnt4); end
            vec++; if (en_cnt1 !== 1 || en_cnt4 !== 1 || en_cyc1 !== 1) begin miss++; $display("FAIL load%0d_mem_en got %0d/%0d at %0d want 1/1 at 1", i, en_cnt1, en_cnt4, en_cyc1); end
            vec++; if (be_s1 !== 4'd0 || we_s1 !== 1'b0) begin miss++; $display("FAIL load%0d_be got be %b we %b want 0000 0", i, be_s1, we_s1); end
            vec++; if (rdata1 !== lt[i].e || busy1 !== 1'b0) begin miss++; $display("FAIL load%0d_hold got %h busy %b want %h 0", i, rdata1, busy1, lt[i].e); end
        end
    endtask

    task automatic test_stores;
        run_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 6);
        vec++; if (en_cnt1 !== 1 || en_cyc1 !== 1 || we_s1 !== 1'b1) begin miss++; $display("FAIL sb_mem_en got %0d at %0d we %b want 1 at 1 we 1", en_cnt1, en_cyc1, we_s1); end
        vec++; if (ad_s1 !== 30'h400 || ad_s4 !== 30'h400) begin miss++; $display("FAIL sb_addr got %h/%h want 400", ad_s1, ad_s4); end
        vec++; if (be_s1 !== 4'b1000) begin miss++; $display("FAIL sb_be got %b want 1000", be_s1); end
        vec++; if (wd_s1 !== 32'hA5A5A5A5) begin miss++; $display("FAIL sb_wdata got %h want A5A5A5A5", wd_s1); end
        vec++; if (rdy_cyc1 !== 2 || rdy_cyc4 !== 2 || rdy_cnt1 !== 1) begin miss++; $display("FAIL sb_ready got %0d/%0d cnt %0d want 2/2 cnt 1", rdy_cyc1, rdy_cyc4, rdy_cnt1); end
        vec++; if (rdata1 !== 32'hFFFFF00D) begin miss++; $display("FAIL sb_rdata_kept got %h want FFFFF00D", rdata1); end
        vec++; if (ram1[0] !== 32'hA5000000) begin miss++; $display("FAIL sb_ram got %h want A5000000", ram1[0]); end

        run_req(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 6);
        vec++; if (be_s1 !== 4'b1100 || wd_s1 !== 32'hBEEFBEEF) begin miss++; $display("FAIL sh_hi got be %b data %h want 1100 BEEFBEEF", be_s1, wd_s1); end
        run_req(1'b1, 3'b001, 32'h0000_1000, 32'h0000_1111, 6);
        vec++; if (be_s1 !== 4'b0011 || wd_s1 !== 32'h11111111) begin miss++; $display("FAIL sh_lo got be %b data %h want 0011 11111111", be_s1, wd_s1); end
        vec++; if (ram1[0] !== 32'hBEEF1111) begin miss++; $display("FAIL sh_ram got %h want BEEF1111", ram1[0]); end

        run_req(1'b0, 3'b010, 32'h0000_1000, 32'd0, 9);
        vec++; if (rd_at1 !== 32'hBEEF1111 || rd_at4 !== 32'hBEEF1111) begin miss++; $display("FAIL lw_after_store got %h/%h want BEEF1111", rd_at1, rd_at4); end
    endtask

    task automatic test_back_to_back;
        int n1, n4, e_a, e_b, r1;
        n1 = 0; n4 = 0; e_a = 0; e_b = 0; r1 = 0;
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0000_0010; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        for (int c = 1; c <= 9; c++) begin
            if (mem_en1) begin
                if (n1 == 0) e_a = c; else if (n1 == 1) e_b = c;
                n1++;
            end
            if (mem_en4) n4++;
            if (ready1) r1++;
            if (c == 4) req = 1'b0;
            @(posedge clk); #1;
        end
        we = 1'b0;
        vec++; if (n1 !== 2 || n4 !== 2) begin miss++; $display("FAIL b2b_count got %0d/%0d want 2/2", n1, n4); end
        vec++; if (e_a !== 1 || e_b !== 4) begin miss++; $display("FAIL b2b_spacing got %0d,%0d want 1,4", e_a, e_b); end
        vec++; if (r1 !== 2 || busy1 !== 1'b0) begin miss++; $display("FAIL b2b_ready got %0d busy %b want 2 0", r1, busy1); end
    endtask

    task automatic test_reset_in_wait;
        int bad;
        bad = 0;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0004;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        vec++; if (busy1 !== 1'b1 || busy4 !== 1'b1 || rdata1 === 32'd0) begin miss++; $display("FAIL rst_pre got busy %b/%b rdata %h want 1/1 nonzero", busy1, busy4, rdata1); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vec++; if ({busy1, busy4, ready1, ready4} !== 4'd0) begin miss++; $display("FAIL rst_wait_ctrl got %b want 0000", {busy1, busy4, ready1, ready4}); end
        vec++; if (rdata1 !== 32'd0 || rdata4 !== 32'd0) begin miss++; $display("FAIL rst_wait_rdata got %h/%h want 0/0", rdata1, rdata4); end
        for (int c = 0; c < 8; c++) begin
            if (ready1 || ready4 || mem_en1 || mem_en4) bad++;
            @(posedge clk); #1;
        end
        vec++; if (bad !== 0) begin miss++; $display("FAIL rst_wait_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_misalign;
        run_req(1'b1, 3'b010, 32'h0000_2002, 32'hCAFE_F00D, 6);
`ifdef MISALIGN_TRAP_EN
        vec++; if (rdy_cyc1 !== 1 || err_at1 !== 1'b1) begin miss++; $display("FAIL trap_ready got cyc %0d err %b want 1 1", rdy_cyc1, err_at1); end
        vec++; if (en_cnt1 !== 0 || en_cnt4 !== 0) begin miss++; $display("FAIL trap_no_en got %0d/%0d want 0/0", en_cnt1, en_cnt4); end
        vec++; if (rdata1 !== 32'd0) begin miss++; $display("FAIL trap_rdata got %h want 0", rdata1); end
        run_req(1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 6);
        vec++; if (rdy_cyc1 !== 2 || err_at1 !== 1'b0) begin miss++; $display("FAIL aligned_err got cyc %0d err %b want 2 0", rdy_cyc1, err_at1); end
`else
        vec++; if (en_cnt1 !== 1 || ad_s1 !== 30'h800) begin miss++; $display("FAIL trunc_addr got en %0d addr %h want 1 800", en_cnt1, ad_s1); end
        vec++; if (be_s1 !== 4'b1111 || wd_s1 !== 32'hCAFEF00D) begin miss++; $display("FAIL trunc_be got %b %h want 1111 CAFEF00D", be_s1, wd_s1); end
        vec++; if (rdy_cyc1 !== 2) begin miss++; $display("FAIL trunc_ready got %0d want 2", rdy_cyc1); end
`endif
    endtask

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_back_to_back;
        test_reset_in_wait;
        test_misalign;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
